// File: rtl/alu_fullyconn_pe.sv
// Processing element: 11-bit serially loaded configuration chain driving a 4x4
// operand crossbar, a registered two-input ALU and a 2:1 output bypass mux.
module alu_fullyconn_pe #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            config_en,
    input  logic            config_in,
    output logic            config_out,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic [size-1:0] in2,
    output logic [size-1:0] out0
);

    logic [10:0]     cfg;
    logic [1:0]      alu_op;
    logic            out_sel;
    logic [1:0]      xsel [4];
    logic [size-1:0] xo [4];
    logic [size-1:0] alu_q;
    logic [size-1:0] alu_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if (config_en) begin
            cfg <= {cfg[9:0], config_in};
        end
    end

    assign config_out = cfg[10];
    assign alu_op     = cfg[1:0];
    assign out_sel    = cfg[2];

    // Each crossbar output reads its own 2-bit field; alu_q is a register, so
    // selecting it breaks any loop through the ALU.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            xsel[k] = cfg[4+2*k -: 2];
            case (xsel[k])
                2'b00:   xo[k] = in0;
                2'b01:   xo[k] = in1;
                2'b10:   xo[k] = in2;
                default: xo[k] = alu_q;
            endcase
        end
    end

    // xo[2] and xo[3] are reserved for extension and intentionally not consumed.
    always_comb begin
        alu_d = '0;
        case (alu_op)
            2'b00:   alu_d = xo[0] + xo[1];
            2'b01:   alu_d = xo[0] - xo[1];
            2'b10:   alu_d = xo[0] & xo[1];
            default: alu_d = xo[0] | xo[1];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q <= '0;
        end else if (!config_en) begin
            alu_q <= alu_d;
        end
    end

    assign out0 = out_sel ? in2 : alu_q;

endmodule

// File: tb/tb_alu_fullyconn_pe.sv
// Directed bench for alu_fullyconn_pe: expected out0 values are queued when
// stimulus is applied and popped when the result is observed.
module tb_alu_fullyconn_pe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         config_en;
    logic         config_in;
    logic         config_out;
    logic [W-1:0] in0, in1, in2;
    logic [W-1:0] out0;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q [$];

    alu_fullyconn_pe #(.size(W)) dut (
        .clk(clk),
        .reset(reset),
        .config_en(config_en),
        .config_in(config_in),
        .config_out(config_out),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .out0(out0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, out0=%h", tag, out0);
        end else begin
            e = exp_q.pop_front();
            assert (out0 === e) else begin
                miscompares++;
                $error("FAIL %s: out0=%h expected %h", tag, out0, e);
            end
        end
    endtask

    task automatic check_cfg(input string tag, input logic e);
        vectors++;
        assert (config_out === e) else begin
            miscompares++;
            $error("FAIL %s: config_out=%b expected %b", tag, config_out, e);
        end
    endtask

    // Shift an 11-bit word MSB first, optionally checking config_out against
    // the word previously held in the chain.
    task automatic load_word(input logic [10:0] w, input logic chk, input logic [10:0] prev);
        config_en = 1'b1;
        for (int i = 10; i >= 0; i--) begin
            if (chk) check_cfg("chain_out", prev[i]);
            config_in = w[i];
            in1 = $urandom;
            tick();
        end
        config_en = 1'b0;
        config_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1; config_en = 1'b0; config_in = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;
        #2;
        expect_out('0);
        check_out("reset_out0");
        check_cfg("reset_cfg", 1'b0);
        // clk edges, config_en and config_in are ignored while reset is high
        config_en = 1'b1; config_in = 1'b1; in0 = 32'd9;
        tick(); tick();
        check_cfg("reset_hold_cfg", 1'b0);
        expect_out('0);
        check_out("reset_hold_out0");
        reset = 1'b0; config_en = 1'b0; config_in = 1'b0;
        // default configuration: add in0 + in0
        expect_out(32'd18);
        tick();
        check_out("default_add");

        load_word(11'h020, 1'b0, 11'h000);
        in0 = 32'd5; in1 = 32'd7;
        expect_out(32'd12);
        tick();
        check_out("add");

        load_word(11'h021, 1'b0, 11'h000);
        in0 = 32'd3; in1 = 32'd5;
        expect_out(32'hFFFF_FFFE);
        tick();
        check_out("sub_wrap");

        load_word(11'h022, 1'b0, 11'h000);
        in0 = 32'h0000_F0F0; in1 = 32'h0000_FF00;
        expect_out(32'h0000_F000);
        tick();
        check_out("and");

        load_word(11'h023, 1'b0, 11'h000);
        in0 = 32'h0000_F0F0; in1 = 32'h0000_FF00;
        expect_out(32'h0000_FFF0);
        tick();
        check_out("or");

        load_word(11'h030, 1'b0, 11'h000);
        in2 = 32'h1000_0000; in1 = 32'h0000_0022;
        expect_out(32'h1000_0022);
        tick();
        check_out("xbar_in2");

        load_word(11'h004, 1'b0, 11'h000);
        in2 = 32'hDEAD_BEEF;
        #1;
        expect_out(32'hDEAD_BEEF);
        check_out("bypass");
        in2 = 32'h1234_5678;
        #1;
        expect_out(32'h1234_5678);
        check_out("bypass_change");

        // reset mid-shift discards the partial word
        config_en = 1'b1; config_in = 1'b1;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        config_en = 1'b0; config_in = 1'b0;
        check_cfg("reset_midshift_cfg", 1'b0);
        in0 = 32'd4;
        expect_out(32'd8);
        tick();
        check_out("after_midshift_reset");

        // accumulate: clear alu_q, then feed alu_q + in1
        reset = 1'b1; #1 reset = 1'b0;
        load_word(11'h038, 1'b0, 11'h000);
        in1 = 32'd1;
        for (int n = 1; n <= 4; n++) begin
            expect_out(n);
            tick();
            check_out("accumulate");
        end

        // chain replays the held word MSB first; alu_q holds while shifting
        load_word(11'h438, 1'b1, 11'h038);
        #1;
        expect_out(32'd4);
        check_out("hold_while_shift");
        check_cfg("chain_msb", 1'b1);
        in1 = 32'd1;
        expect_out(32'd5);
        tick();
        check_out("accumulate_resume");

        // asynchronous reset between edges
        #3 reset = 1'b1;
        #1;
        expect_out('0);
        check_out("async_reset_out0");
        check_cfg("async_reset_cfg", 1'b0);
        reset = 1'b0;
        in0 = 32'd21;
        expect_out(32'd42);
        tick();
        check_out("post_reset_default");

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
